program_counter: RTL and testbench
==================================

# program_counter

Architectural program counter register for the fetch stage of the RV32i pipelined processor. It holds the address of the instruction being fetched. Each cycle it loads the next-PC value chosen upstream (sequential PC+4 or a redirect target), or it holds its value during pipeline stalls. Next-PC arithmetic and selection are done outside this block; the block is purely the stateful register with reset and enable control.

## Interface
Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  one clock; reset is synchronous and active-low (RST = 0 resets on the next rising CLK edge).
- PC_En  input  1  update enable; 1 = load PC_In, 0 = stall (hold).
- PC_In  input  WIDTH  next-PC value from the fetch next-PC mux.
- PC_Out  output  WIDTH  current PC; a direct register output with no combinational path from any input.

## Operation
- Single WIDTH-bit register drives PC_Out.
- Priority at each rising CLK edge:
  - RST == 0: PC_Out <= RESET_VECTOR. PC_En and PC_In are ignored.
  - RST == 1 and PC_En == 1: PC_Out <= PC_In.
  - RST == 1 and PC_En == 0: PC_Out <= PC_Out (stall).
- No alignment masking, no increment, no range checking. Any 32-bit value loads verbatim, including 32'hFFFF_FFFE, 32'hFFFF_FFFF and odd addresses.
- Misaligned-address detection is the responsibility of other blocks.
- Stall has no maximum duration. PC_Out stays constant for as many cycles as PC_En stays 0.
- The power-up value before the first reset is undefined. The system guarantees at least one reset cycle before fetch begins.
- Reset may be asserted at any time, including mid-stall or mid-operation. It always wins on that edge.

## Timing
- Latency is 1 cycle. A value on PC_In sampled at edge N appears on PC_Out after edge N and remains until at least edge N+1.
- Reset latency is 1 cycle. With RST = 0 sampled at edge N, PC_Out = RESET_VECTOR after edge N.
- Reset is synchronous. Asserting or deasserting RST between edges has no effect until the next rising edge.
- On the first edge with RST = 1 after reset, PC_En is honoured immediately. There are no dead cycles.
- PC_Out changes only at rising CLK edges. It is glitch-free between edges.
- Reset value of PC_Out: RESET_VECTOR (0x0000_0000 by default).

## Test plan
- Reset: drive RST = 0, PC_En = 0, PC_In = 0 for one edge, then RST = 0 with PC_In = 32'h1234_5678 and PC_En = 1 -> PC_Out = 0 after each reset edge; reset overrides enable.
- Boundary loads: release reset with PC_En = 1. Drive PC_In = 32'hFFFF_FFFE, then 32'hFFFF_FFFF on consecutive edges -> PC_Out follows one cycle later with exact values and no masking or wrap.
- Random operation: with RST = 1 and PC_En = 1, drive random PC_In for up to 10 cycles -> every cycle PC_Out equals PC_In from the previous edge.
- Stall: hold PC_En = 0 for a random 0–20 cycles while PC_In changes randomly -> PC_Out is unchanged throughout. Then PC_En = 1 with PC_In = 32'h8 -> PC_Out = 32'h8 after one edge.
- Mid-operation reset: during random updates, pulse RST = 0 for exactly one edge -> PC_Out = 0 after that edge. On the next edge with RST = 1 and PC_En = 1, PC_Out equals the new PC_In.
- Continuous checks, run throughout all scenarios:
  - After any edge with RST = 0, PC_Out == RESET_VECTOR.
  - After any edge with RST = 1 and PC_En = 1, PC_Out == $past(PC_In).
  - After any edge with RST = 1 and PC_En = 0, PC_Out == $past(PC_Out).

Source files
------------

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Fetch-stage PC register with synchronous active-low reset and
//               load enable; stalls hold the current value.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter int unsigned           WIDTH        = 32,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PC_En,
    input  logic [WIDTH-1:0] PC_In,
    output logic [WIDTH-1:0] PC_Out
);

    // Reset outranks enable; values load verbatim with no alignment masking.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            PC_Out <= RESET_VECTOR;
        end else if (PC_En) begin
            PC_Out <= PC_In;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Scoreboard bench for program_counter with randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        CLK;
    logic        RST;
    logic        PC_En;
    logic [31:0] PC_In;
    logic [31:0] PC_Out;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_pc;
    int          total;
    int          bad;

    program_counter #(
        .WIDTH       (32),
        .RESET_VECTOR(RV)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .PC_En (PC_En),
        .PC_In (PC_In),
        .PC_Out(PC_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Architectural rule: reset wins, else enable loads, else hold.
    task automatic step(input logic rst, input logic en, input logic [31:0] din,
                        input string tag);
        exp_t e;
        @(negedge CLK);
        RST   = rst;
        PC_En = en;
        PC_In = din;
        if (!rst)    model_pc = RV;
        else if (en) model_pc = din;
        e.exp = model_pc;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (PC_Out !== e.exp) begin
                bad++;
                $display("FAIL %s: PC_Out=%h expected=%h at %0t", e.tag, PC_Out, e.exp, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total    = 0;
        bad      = 0;
        model_pc = 'x;
        RST      = 1'b0;
        PC_En    = 1'b0;
        PC_In    = '0;

        // Reset, then reset overriding an enabled load
        step(1'b0, 1'b0, 32'h0, "reset_idle");
        step(1'b0, 1'b1, 32'h1234_5678, "reset_over_enable");

        // Boundary values load verbatim
        step(1'b1, 1'b1, 32'hFFFF_FFFE, "load_fffffffe");
        step(1'b1, 1'b1, 32'hFFFF_FFFF, "load_ffffffff");
        step(1'b1, 1'b1, 32'h0000_0003, "load_odd");

        // Random consecutive loads
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, $urandom, "random_load");

        // Stall of random length with changing input
        n = $urandom_range(0, 20);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, $urandom, "stall_hold");
        step(1'b1, 1'b1, 32'h0000_0008, "resume_load_8");

        // One-edge reset in the middle of updates
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, $urandom, "pre_reset_load");
        step(1'b0, 1'b1, $urandom, "mid_op_reset");
        step(1'b1, 1'b1, $urandom, "post_reset_load");

        // Reset asserted during a stall
        step(1'b1, 1'b0, $urandom, "stall_before_reset");
        step(1'b0, 1'b0, $urandom, "reset_in_stall");
        step(1'b1, 1'b0, $urandom, "stall_after_reset");

        // Mixed random traffic
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1, $urandom, "mixed_random");

        repeat (2) @(posedge CLK);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
